// File: rtl/fan_ctrl_multi.sv
// rtl/fan_ctrl_multi.sv - multi-channel NTC thermistor fan controller with spin-up kick and minimum on-time
//
// Watches CH thermistor ADC codes (NTC: lower code = hotter). Cooling starts when any
// channel is hotter than on_thr. It stops once every channel is colder than off_thr and
// the fan has been on for at least MIN_ON_CYC cycles. A new fan start always begins with
// SPINUP_CYC cycles at full drive. After that the fan runs at PWM duty 'duty'.
//
// Optional feature macro: FAN_CTRL_OVERTEMP_ALARM_EN
//   Defined   : latched overtemperature alarm (any code < alarm_thr). While the alarm
//               is set, the fan runs at full duty.
//   Undefined : alarm tied low; alarm_thr and alarm_clr are ignored.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   sample_valid cur_adc is valid this cycle
//   cur_adc      packed channel codes, channel k at [k*ADC_W +: ADC_W]
//   on_thr       start-cooling code
//   off_thr      stop-cooling code
//   duty         RUN-state PWM duty
//   alarm_thr    overtemperature code
//   alarm_clr    clears the latched alarm
//   fan_on       fan enabled (state != IDLE)
//   fan_pwm      fan drive
//   state        IDLE=0, SPINUP=1, RUN=2
//   hot_mask     per-channel "code < on_thr" at the last sample
//   cfg_err      on_thr >= off_thr (combinational)
//   alarm        latched overtemperature
module fan_ctrl_multi #(
  parameter int CH         = 4,
  parameter int ADC_W      = 12,
  parameter int PWM_W      = 8,
  parameter int SPINUP_CYC = 1000,
  parameter int MIN_ON_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [CH*ADC_W-1:0] cur_adc,
  input  logic [ADC_W-1:0]    on_thr,
  input  logic [ADC_W-1:0]    off_thr,
  input  logic [PWM_W-1:0]    duty,
  input  logic [ADC_W-1:0]    alarm_thr,
  input  logic                alarm_clr,
  output logic                fan_on,
  output logic                fan_pwm,
  output logic [1:0]          state,
  output logic [CH-1:0]       hot_mask,
  output logic                cfg_err,
  output logic                alarm
);

  localparam int TW = $clog2(MIN_ON_CYC + 1);
  localparam logic [TW-1:0] SPIN_LAST = TW'(SPINUP_CYC - 1);
  localparam logic [TW-1:0] MIN_LAST  = TW'(MIN_ON_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPINUP = 2'd1,
    S_RUN    = 2'd2,
    S_BAD    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d, timer_inc;
  logic [PWM_W-1:0]   pwm_cnt_q;
  logic [CH-1:0]      hot_mask_q;
  logic               demand_q, release_q;
  logic               alarm_q;
  logic [CH-1:0]      hot_now, rel_now;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    assign hot_now[k] = cur_adc[k*ADC_W +: ADC_W] < on_thr;
    assign rel_now[k] = cur_adc[k*ADC_W +: ADC_W] > off_thr;
  end

  // An inverted or collapsed hysteresis band cannot be trusted: fail safe to cooling.
  assign cfg_err = on_thr >= off_thr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pwm_cnt_q  <= '0;
      hot_mask_q <= '0;
      demand_q   <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      // demand/release are held as levels between samples, so a release seen early in
      // RUN is remembered until the on-timer expires or a later sample withdraws it.
      if (sample_valid) begin
        hot_mask_q <= hot_now;
        demand_q   <= cfg_err | (|hot_now);
        release_q  <= ~cfg_err & (&rel_now);
      end
    end
  end

`ifdef FAN_CTRL_OVERTEMP_ALARM_EN
  logic [CH-1:0] alm_now;
  for (genvar k = 0; k < CH; k++) begin : g_alm
    assign alm_now[k] = cur_adc[k*ADC_W +: ADC_W] < alarm_thr;
  end

  // Set has priority over clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else if (sample_valid && (|alm_now)) begin
      alarm_q <= 1'b1;
    end else if (alarm_clr) begin
      alarm_q <= 1'b0;
    end
  end
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_thr, alarm_clr};
  assign alarm_q = 1'b0;
`endif

  // On-time counter starts at SPINUP entry and saturates at MIN_ON_CYC-1.
  assign timer_inc = (timer_q >= MIN_LAST) ? MIN_LAST : timer_q + 1'b1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (demand_q) begin
          state_d = S_SPINUP;
          timer_d = '0;
        end
      end
      S_SPINUP: begin
        timer_d = timer_inc;
        if (timer_q == SPIN_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_inc;
        if (release_q && (timer_q >= MIN_LAST)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fan_pwm = 1'b0;
    case (state_q)
      S_SPINUP: fan_pwm = 1'b1;
      S_RUN:    fan_pwm = alarm_q | (pwm_cnt_q < duty);
      default:  fan_pwm = 1'b0;
    endcase
  end

  assign fan_on   = (state_q != S_IDLE);
  assign state    = state_q;
  assign hot_mask = hot_mask_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// tb/tb_fan_ctrl_multi.sv - scoreboard testbench for fan_ctrl_multi
module tb_fan_ctrl_multi;

  localparam int CH    = 4;
  localparam int ADC_W = 12;
  localparam int PWM_W = 8;
  localparam int SPIN  = 1000;
  localparam int MINON = 3000;

  localparam int K_STATE  = 0;
  localparam int K_PWM    = 1;
  localparam int K_HOT    = 2;
  localparam int K_FANON  = 3;
  localparam int K_CFG    = 4;
  localparam int K_ALARM  = 5;
  localparam int K_PWMCNT = 6;

  localparam int HIST_N = 40000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                sample_valid;
  logic [CH*ADC_W-1:0] cur_adc;
  logic [ADC_W-1:0]    on_thr, off_thr, alarm_thr;
  logic [PWM_W-1:0]    duty;
  logic                alarm_clr;
  logic                fan_on, fan_pwm, cfg_err, alarm;
  logic [1:0]          state;
  logic [CH-1:0]       hot_mask;

  typedef struct {
    int    due;
    int    kind;
    int    start;
    int    exp;
    string name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   hist [0:HIST_N-1];

  fan_ctrl_multi #(
    .CH(CH), .ADC_W(ADC_W), .PWM_W(PWM_W), .SPINUP_CYC(SPIN), .MIN_ON_CYC(MINON)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .cur_adc(cur_adc),
    .on_thr(on_thr), .off_thr(off_thr), .duty(duty), .alarm_thr(alarm_thr),
    .alarm_clr(alarm_clr), .fan_on(fan_on), .fan_pwm(fan_pwm), .state(state),
    .hot_mask(hot_mask), .cfg_err(cfg_err), .alarm(alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples outputs shortly after the falling edge, pops every expectation
  // that is due in this cycle and compares it.
  always @(negedge clk) begin
    int i;
    int act;
    #2;
    if (cyc < HIST_N) hist[cyc] = fan_pwm;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_STATE:  act = int'(state);
          K_PWM:    act = int'(fan_pwm);
          K_HOT:    act = int'(hot_mask);
          K_FANON:  act = int'(fan_on);
          K_CFG:    act = int'(cfg_err);
          K_ALARM:  act = int'(alarm);
          default: begin
            act = 0;
            for (int j = sb[i].start; j <= cyc; j++) act += int'(hist[j]);
          end
        endcase
        checks++;
        if (act != sb[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0d exp=%0d", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed due=%0d now=%0d", sb[i].name, sb[i].due, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic exp_at(input int c, input int kind, input int e, input string name);
    chk_t x;
    x.due = c; x.kind = kind; x.start = 0; x.exp = e; x.name = name;
    sb.push_back(x);
  endtask

  task automatic exp_cnt(input int s, input int len, input int e, input string name);
    chk_t x;
    x.due = s + len - 1; x.kind = K_PWMCNT; x.start = s; x.exp = e; x.name = name;
    sb.push_back(x);
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < CH; k++) cur_adc[k*ADC_W +: ADC_W] = ADC_W'(v);
  endtask

  task automatic set_ch(input int k, input int v);
    cur_adc[k*ADC_W +: ADC_W] = ADC_W'(v);
  endtask

  task automatic sample_now();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    int t, t0, ta, tc, tl;
    rst_n = 1'b0; sample_valid = 1'b0; alarm_clr = 1'b0;
    on_thr = 12'd1500; off_thr = 12'd2500; duty = 8'd64; alarm_thr = 12'd800;
    set_all(2000);
    repeat (3) step();
    rst_n = 1'b1;

    t = cyc;
    exp_at(t, K_STATE, 0, "rst_state");
    exp_at(t, K_PWM,   0, "rst_pwm");
    exp_at(t, K_HOT,   0, "rst_hot");
    exp_at(t, K_FANON, 0, "rst_fan_on");
    exp_at(t, K_ALARM, 0, "rst_alarm");
    exp_at(t, K_CFG,   0, "cfg_ok");
    repeat (2) step();

    // Codes equal to on_thr are not hot.
    set_all(1500);
    t = cyc;
    sample_now();
    exp_at(t + 1, K_HOT,   0, "eq_on_thr_hot");
    exp_at(t + 3, K_STATE, 0, "eq_on_thr_idle");
    repeat (3) step();

    // ch2 hot: spin-up then RUN.
    set_all(2000); set_ch(2, 1400);
    t0 = cyc;
    sample_now();
    exp_at(t0 + 1, K_HOT,   4, "hot_mask_ch2");
    exp_at(t0 + 1, K_STATE, 0, "idle_before_latency");
    exp_at(t0 + 2, K_STATE, 1, "spinup_entry");
    exp_at(t0 + 2, K_FANON, 1, "fan_on_spinup");
    exp_cnt(t0 + 2, SPIN, SPIN, "spinup_full_drive");
    exp_at(t0 + 1001, K_STATE, 1, "spinup_last");
    exp_at(t0 + 1002, K_STATE, 2, "run_entry");

    wait_until(t0 + 1010);
    exp_cnt(cyc, 256, 64, "duty64_window");
    wait_until(t0 + 1270);
    duty = 8'd0;
    exp_cnt(cyc, 256, 0, "duty0_window");
    wait_until(t0 + 1530);
    duty = 8'd255;
    exp_cnt(cyc, 256, 255, "duty255_window");
    wait_until(t0 + 1790);
    duty = 8'd64;

    // Hysteresis band: state held.
    wait_until(t0 + 1800);
    set_all(2000);
    sample_now();
    exp_at(t0 + 1801, K_HOT,   0, "band_hot");
    exp_at(t0 + 1802, K_STATE, 2, "band_run");
    exp_at(t0 + 1950, K_STATE, 2, "band_run_late");

    // Early release: held until the min-on timer expires.
    wait_until(t0 + 2000);
    set_all(2600);
    sample_now();
    exp_at(t0 + 2002, K_STATE, 2, "early_release_run");
    exp_at(t0 + 3001, K_STATE, 2, "release_before_expiry");
    exp_at(t0 + 3002, K_STATE, 0, "release_idle");
    exp_at(t0 + 3002, K_FANON, 0, "release_fan_off");
    exp_cnt(t0 + 3002, 100, 0, "idle_pwm_low");
    wait_until(t0 + 3110);

    // Second run: codes equal to off_thr do not release; then reset mid-RUN.
    ta = cyc;
    set_all(2000); set_ch(2, 1400);
    sample_now();
    exp_at(ta + 2,    K_STATE, 1, "run2_spinup");
    exp_at(ta + 1002, K_STATE, 2, "run2_run");
    wait_until(ta + 1500);
    set_all(2500);
    sample_now();
    exp_at(ta + 1501, K_HOT,   0, "eq_off_thr_hot");
    exp_at(ta + 3010, K_STATE, 2, "eq_off_thr_no_release");
    wait_until(ta + 3015);
    set_ch(3, 1000);
    sample_now();
    exp_at(ta + 3016, K_HOT, 8, "hot_mask_ch3");
    wait_until(ta + 3020);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    t = cyc;
    exp_at(t,     K_STATE, 0, "midrun_rst_state");
    exp_at(t,     K_FANON, 0, "midrun_rst_fan_on");
    exp_at(t,     K_PWM,   0, "midrun_rst_pwm");
    exp_at(t,     K_HOT,   0, "midrun_rst_hot");
    exp_at(t + 3, K_STATE, 0, "rst_clears_demand");
    repeat (4) step();

    // Inverted thresholds: fail-safe cooling with all channels cold.
    on_thr = 12'd3000; off_thr = 12'd2000;
    set_all(3500);
    tc = cyc;
    exp_at(tc, K_CFG, 1, "cfg_err_inverted");
    sample_now();
    exp_at(tc + 1, K_HOT,   0, "cfg_cold_hot");
    exp_at(tc + 2, K_STATE, 1, "cfg_spinup");
    wait_until(tc + 5);
    on_thr = 12'd2000;
    exp_at(cyc, K_CFG, 1, "cfg_err_equal");
    step();
    on_thr = 12'd1500; off_thr = 12'd2500;
    exp_at(cyc, K_CFG, 0, "cfg_err_cleared");
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Overtemperature alarm.
    set_all(2000); set_ch(0, 700);
    tl = cyc;
    sample_now();
    exp_at(tl + 1, K_HOT,   1, "alarm_hot_mask");
    exp_at(tl + 2, K_STATE, 1, "alarm_spinup");
`ifdef FAN_CTRL_OVERTEMP_ALARM_EN
    exp_at(tl + 1, K_ALARM, 1, "alarm_set");
    wait_until(tl + 1010);
    exp_cnt(cyc, 256, 256, "alarm_full_duty");
    wait_until(tl + 1270);
    set_ch(0, 1000);
    sample_now();
    exp_at(tl + 1271, K_ALARM, 1, "alarm_latched");
    wait_until(tl + 1275);
    alarm_clr = 1'b1;
    exp_at(cyc + 1, K_ALARM, 0, "alarm_cleared");
    step();
    alarm_clr = 1'b0;
    wait_until(tl + 1280);
    exp_cnt(cyc, 256, 64, "post_alarm_duty64");
    wait_until(tl + 1540);
    set_ch(0, 700);
    alarm_clr = 1'b1;
    exp_at(cyc + 1, K_ALARM, 1, "alarm_set_wins");
    sample_now();
    alarm_clr = 1'b0;
`else
    exp_at(tl + 1, K_ALARM, 0, "alarm_tied_low");
    wait_until(tl + 1010);
    exp_cnt(cyc, 256, 64, "no_alarm_duty64");
    exp_at(cyc + 5, K_ALARM, 0, "alarm_still_low");
    wait_until(tl + 1270);
`endif
    repeat (5) step();

    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s never_checked due=%0d now=%0d", sb[0].name, sb[0].due, cyc);
      sb.delete(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fan_ctrl_multi.md
FAN_CTRL_MULTI -- requirements
Module: fan_ctrl_multi

Interface
REQ-001 SHALL have parameter CH, default 4: number of thermistor channels.
REQ-002 SHALL have parameter ADC_W, default 12: ADC code width.
REQ-003 SHALL have parameter PWM_W, default 8: PWM counter and duty width.
REQ-004 SHALL have parameter SPINUP_CYC, default 1000: full-duty kick length in clk cycles, >=1.
REQ-005 SHALL have parameter MIN_ON_CYC, default 50000: minimum fan-on time in clk cycles, >= SPINUP_CYC.
REQ-006 SHALL have ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset is synchronous and active-low
sample_valid  in  1  strobe, cur_adc valid this cycle
cur_adc  in  CH*ADC_W  channel k at bits [k*ADC_W +: ADC_W]
on_thr  in  ADC_W  start-cooling code (hot = lower code, NTC)
off_thr  in  ADC_W  stop-cooling code
duty  in  PWM_W  RUN-state duty
alarm_thr  in  ADC_W  overtemperature code
alarm_clr  in  1  clears latched alarm
fan_on  out  1  fan enabled (state != IDLE)
fan_pwm  out  1  fan drive
state  out  2  IDLE=0, SPINUP=1, RUN=2
hot_mask  out  CH  bit k = channel k code < on_thr at last sample
cfg_err  out  1  on_thr >= off_thr
alarm  out  1  latched overtemperature

Function
REQ-007 SHALL evaluate thresholds only in cycles with sample_valid=1; registered results (hot_mask, demand, release) update on that edge, state reacts on the following edge (2-cycle sample-to-state latency).
REQ-008 SHALL assert demand when any channel code < on_thr; release when every channel code > off_thr; neither = hysteresis band, state held.
REQ-009 SHALL use unsigned ADC_W comparisons; codes equal to a threshold count as not hot and not released.
REQ-010 SHALL drive cfg_err combinationally from on_thr >= off_thr; while 1, demand forced to 1 and release to 0 (fail-safe cooling).
REQ-011 SHALL transition IDLE->SPINUP on demand, loading on-timer to 0.
REQ-012 SHALL hold SPINUP with fan_pwm=1 constantly until on-timer reaches SPINUP_CYC-1, then enter RUN.
REQ-013 SHALL in RUN drive fan_pwm = (pwm_cnt < duty), pwm_cnt a free-running PWM_W-bit wrapping counter; duty=0 gives constant 0, duty=2^PWM_W-1 gives 2^PWM_W-1 of 2^PWM_W high.
REQ-014 SHALL leave RUN for IDLE only when release is registered and on-timer >= MIN_ON_CYC-1; release arriving earlier is remembered and honoured when timer expires unless a later sample clears it.
REQ-015 SHALL saturate the on-timer at MIN_ON_CYC-1; the timer counts from SPINUP entry.
REQ-016 SHALL treat demand and release never simultaneous except via cfg_err rule; demand during RUN keeps RUN.
REQ-017 SHALL map unused state encoding 3 to IDLE on the next edge.
REQ-018 SHALL drive fan_pwm=0 in IDLE.

Reset
REQ-019 SHALL on rst_n=0 at a clock edge set state=IDLE, fan_on=0, fan_pwm=0, hot_mask=0, on-timer=0, pwm_cnt=0, pending release=0, alarm=0, regardless of current state (mid-SPINUP/RUN abort allowed).
REQ-020 SHALL resume threshold evaluation only from the first sample_valid after rst_n returns high.

Configuration
REQ-021 SHALL with FAN_CTRL_OVERTEMP_ALARM_EN defined set alarm=1 on any sampled channel code < alarm_thr, hold it until alarm_clr=1 with no alarm condition in that cycle (set wins over clear), and force SPINUP/RUN duty to full while alarm=1.
REQ-022 SHALL without FAN_CTRL_OVERTEMP_ALARM_EN tie alarm to 0 and ignore alarm_thr and alarm_clr.

Verification
REQ-023 SHALL cover: CH=4, on_thr=1500, off_thr=2500, ch2=1400 with sample_valid -> hot_mask=4'b0100, state SPINUP two edges later, fan_pwm=1 for 1000 cycles, then RUN.
REQ-024 SHALL cover: RUN, duty=64 -> fan_pwm high exactly 64 of every 256 cycles.
REQ-025 SHALL cover: all channels 2000 (band) -> state unchanged; all 2600 before MIN_ON_CYC -> stays RUN until timer expiry, then IDLE.
REQ-026 SHALL cover: on_thr=3000, off_thr=2000 -> cfg_err=1, fan enters SPINUP with all channels cold.
REQ-027 SHALL cover: rst_n=0 mid-RUN for one edge -> all outputs 0, state IDLE next cycle.
REQ-028 SHALL cover (macro on): alarm_thr=800, ch0=700 -> alarm=1, full duty; ch0=1000 then alarm_clr=1 -> alarm=0.
